// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers issued ops until both operands are known and dispatches one per cycle.
// Optional macro RS_CDB_BYPASS_EN: an entry woken by the CDB may dispatch in the same cycle using the broadcast value.
module alu_reservation_station #(
    parameter int RS_DEPTH  = 16,
    parameter int ROB_WIDTH = 4,
    parameter int OP_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 Clear,
    input  logic                 Issue_S,
    input  logic [OP_WIDTH-1:0]  Issue_Op,
    input  logic [31:0]          Issue_Vj,
    input  logic [31:0]          Issue_Vk,
    input  logic                 Issue_Qj_S,
    input  logic                 Issue_Qk_S,
    input  logic [ROB_WIDTH-1:0] Issue_Qj,
    input  logic [ROB_WIDTH-1:0] Issue_Qk,
    input  logic [ROB_WIDTH-1:0] Issue_Reorder,
    input  logic [31:0]          Issue_A,
    input  logic [31:0]          Issue_pc,
    input  logic                 CDB_ALU_S,
    input  logic [ROB_WIDTH-1:0] CDB_ALU_Reorder,
    input  logic [31:0]          CDB_ALU_Value,
    input  logic                 CDB_LSB_S,
    input  logic [ROB_WIDTH-1:0] CDB_LSB_Reorder,
    input  logic [31:0]          CDB_LSB_Value,
    output logic                 RS_Full,
    output logic                 ALU_S,
    output logic [OP_WIDTH-1:0]  Op,
    output logic [31:0]          Vj,
    output logic [31:0]          Vk,
    output logic [31:0]          A,
    output logic [31:0]          pc,
    output logic [ROB_WIDTH-1:0] Reorder
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    typedef struct packed {
        logic [OP_WIDTH-1:0]  op;
        logic [31:0]          vj;
        logic [31:0]          vk;
        logic                 qj_s;
        logic [ROB_WIDTH-1:0] qj;
        logic                 qk_s;
        logic [ROB_WIDTH-1:0] qk;
        logic [ROB_WIDTH-1:0] reorder;
        logic [31:0]          a;
        logic [31:0]          pc;
    } entry_t;

    logic [RS_DEPTH-1:0] busy;
    entry_t              ent   [RS_DEPTH];
    entry_t              woken [RS_DEPTH];
    logic [RS_DEPTH-1:0] ready;
    entry_t              new_ent;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic                any_ready;
    logic                issue_fire;
    logic                alu_s_q;

    // ALU broadcast wins when both buses carry the tag (an illegal case upstream).
    function automatic logic cdb_hit(input logic [ROB_WIDTH-1:0] tag);
        return (CDB_ALU_S && CDB_ALU_Reorder == tag) || (CDB_LSB_S && CDB_LSB_Reorder == tag);
    endfunction

    function automatic logic [31:0] cdb_value(input logic [ROB_WIDTH-1:0] tag);
        return (CDB_ALU_S && CDB_ALU_Reorder == tag) ? CDB_ALU_Value : CDB_LSB_Value;
    endfunction

    assign RS_Full    = &busy;
    assign ALU_S      = alu_s_q & rdy;
    assign issue_fire = Issue_S && !RS_Full;

    // Each entry as it would look after this cycle's broadcasts.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            woken[i] = ent[i];
            if (ent[i].qj_s && cdb_hit(ent[i].qj)) begin
                woken[i].qj_s = 1'b0;
                woken[i].vj   = cdb_value(ent[i].qj);
            end
            if (ent[i].qk_s && cdb_hit(ent[i].qk)) begin
                woken[i].qk_s = 1'b0;
                woken[i].vk   = cdb_value(ent[i].qk);
            end
`ifdef RS_CDB_BYPASS_EN
            ready[i] = busy[i] && !woken[i].qj_s && !woken[i].qk_s;
`else
            ready[i] = busy[i] && !ent[i].qj_s && !ent[i].qk_s;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred on any path.
    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        any_ready = 1'b0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
            if (ready[i]) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    always_comb begin
        new_ent = '{op: Issue_Op, vj: Issue_Vj, vk: Issue_Vk,
                    qj_s: Issue_Qj_S, qj: Issue_Qj, qk_s: Issue_Qk_S, qk: Issue_Qk,
                    reorder: Issue_Reorder, a: Issue_A, pc: Issue_pc};
        if (Issue_Qj_S && cdb_hit(Issue_Qj)) begin
            new_ent.qj_s = 1'b0;
            new_ent.vj   = cdb_value(Issue_Qj);
        end
        if (Issue_Qk_S && cdb_hit(Issue_Qk)) begin
            new_ent.qk_s = 1'b0;
            new_ent.vk   = cdb_value(Issue_Qk);
        end
    end

    // NOTE: the payload array carries no reset; busy alone says whether an entry's contents mean anything.
    always_ff @(posedge clk) begin
        if (rdy && !Clear) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy[i]) ent[i] <= woken[i];
            end
            if (issue_fire) ent[free_idx] <= new_ent;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            alu_s_q <= 1'b0;
            Op      <= '0;
            Vj      <= '0;
            Vk      <= '0;
            A       <= '0;
            pc      <= '0;
            Reorder <= '0;
        end else if (!rdy) begin
            alu_s_q <= 1'b0;
        end else if (Clear) begin
            busy    <= '0;
            alu_s_q <= 1'b0;
        end else begin
            alu_s_q <= any_ready;
            if (any_ready) begin
                busy[sel_idx] <= 1'b0;
                Op            <= woken[sel_idx].op;
                Vj            <= woken[sel_idx].vj;
                Vk            <= woken[sel_idx].vk;
                A             <= woken[sel_idx].a;
                pc            <= woken[sel_idx].pc;
                Reorder       <= woken[sel_idx].reorder;
            end
            if (issue_fire) busy[free_idx] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: vector table, directed corner sequences, randomized run vs. a reference model.
// Expectations follow RS_CDB_BYPASS_EN when it is defined for the build.
module tb_alu_reservation_station;
    localparam int DEPTH = 16;
    localparam int OUT_W = 138;
`ifdef RS_CDB_BYPASS_EN
    localparam int WAKE_LAT = 1;
`else
    localparam int WAKE_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        Clear = 1'b0;
    logic        Issue_S = 1'b0;
    logic [5:0]  Issue_Op = '0;
    logic [31:0] Issue_Vj = '0, Issue_Vk = '0, Issue_A = '0, Issue_pc = '0;
    logic        Issue_Qj_S = 1'b0, Issue_Qk_S = 1'b0;
    logic [3:0]  Issue_Qj = '0, Issue_Qk = '0, Issue_Reorder = '0;
    logic        CDB_ALU_S = 1'b0, CDB_LSB_S = 1'b0;
    logic [3:0]  CDB_ALU_Reorder = '0, CDB_LSB_Reorder = '0;
    logic [31:0] CDB_ALU_Value = '0, CDB_LSB_Value = '0;
    logic        RS_Full, ALU_S;
    logic [5:0]  Op;
    logic [31:0] Vj, Vk, A, pc;
    logic [3:0]  Reorder;
    logic [OUT_W-1:0] dut_out;

    assign dut_out = {Op, Vj, Vk, A, pc, Reorder};

    alu_reservation_station #(.RS_DEPTH(DEPTH), .ROB_WIDTH(4), .OP_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .Clear(Clear),
        .Issue_S(Issue_S), .Issue_Op(Issue_Op), .Issue_Vj(Issue_Vj), .Issue_Vk(Issue_Vk),
        .Issue_Qj_S(Issue_Qj_S), .Issue_Qk_S(Issue_Qk_S), .Issue_Qj(Issue_Qj), .Issue_Qk(Issue_Qk),
        .Issue_Reorder(Issue_Reorder), .Issue_A(Issue_A), .Issue_pc(Issue_pc),
        .CDB_ALU_S(CDB_ALU_S), .CDB_ALU_Reorder(CDB_ALU_Reorder), .CDB_ALU_Value(CDB_ALU_Value),
        .CDB_LSB_S(CDB_LSB_S), .CDB_LSB_Reorder(CDB_LSB_Reorder), .CDB_LSB_Value(CDB_LSB_Value),
        .RS_Full(RS_Full), .ALU_S(ALU_S), .Op(Op), .Vj(Vj), .Vk(Vk), .A(A), .pc(pc), .Reorder(Reorder)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Issue_S = 1'b0; Clear = 1'b0; Issue_Qj_S = 1'b0; Issue_Qk_S = 1'b0;
        CDB_ALU_S = 1'b0; CDB_LSB_S = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic qj_s, input logic [3:0] qj, input logic qk_s, input logic [3:0] qk,
                         input logic [3:0] rob, input logic [31:0] a, input logic [31:0] p);
        Issue_S = 1'b1; Issue_Op = op; Issue_Vj = vj; Issue_Vk = vk;
        Issue_Qj_S = qj_s; Issue_Qj = qj; Issue_Qk_S = qk_s; Issue_Qk = qk;
        Issue_Reorder = rob; Issue_A = a; Issue_pc = p;
    endtask

    // ---------------- reference model: slots holding ops, -1 marks a known operand ----------------
    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] vj, vk, a, pc;
        int          qj, qk;
        logic [3:0]  rob;
    } m_ent_t;

    m_ent_t           mdl [DEPTH];
    logic             exp_alu_s;
    logic [OUT_W-1:0] exp_out;

    function automatic bit bus_has(int tag);
        return tag >= 0 && ((CDB_ALU_S && int'(CDB_ALU_Reorder) == tag) ||
                            (CDB_LSB_S && int'(CDB_LSB_Reorder) == tag));
    endfunction

    function automatic logic [31:0] bus_val(int tag);
        return (CDB_ALU_S && int'(CDB_ALU_Reorder) == tag) ? CDB_ALU_Value : CDB_LSB_Value;
    endfunction

    function automatic bit known_now(int q);
`ifdef RS_CDB_BYPASS_EN
        return q < 0 || bus_has(q);
`else
        return q < 0;
`endif
    endfunction

    function automatic bit model_full();
        int n = 0;
        foreach (mdl[i]) if (mdl[i].busy) n++;
        return n == DEPTH;
    endfunction

    task automatic model_reset();
        foreach (mdl[i]) mdl[i].busy = 1'b0;
        exp_alu_s = 1'b0;
        exp_out   = '0;
    endtask

    // Advances the model across one clock edge using the inputs currently driven.
    task automatic model_edge();
        int     sel = -1;
        int     fr  = -1;
        m_ent_t e;
        if (!rdy) begin
            exp_alu_s = 1'b0;
            return;
        end
        if (Clear) begin
            foreach (mdl[i]) mdl[i].busy = 1'b0;
            exp_alu_s = 1'b0;
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!mdl[i].busy && fr < 0) fr = i;
            if (mdl[i].busy && sel < 0 && known_now(mdl[i].qj) && known_now(mdl[i].qk)) sel = i;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (mdl[i].busy && bus_has(mdl[i].qj)) begin mdl[i].vj = bus_val(mdl[i].qj); mdl[i].qj = -1; end
            if (mdl[i].busy && bus_has(mdl[i].qk)) begin mdl[i].vk = bus_val(mdl[i].qk); mdl[i].qk = -1; end
        end
        exp_alu_s = (sel >= 0);
        if (sel >= 0) begin
            exp_out = {mdl[sel].op, mdl[sel].vj, mdl[sel].vk, mdl[sel].a, mdl[sel].pc, mdl[sel].rob};
            mdl[sel].busy = 1'b0;
        end
        if (Issue_S && fr >= 0) begin
            e.busy = 1'b1; e.op = Issue_Op; e.vj = Issue_Vj; e.vk = Issue_Vk;
            e.a = Issue_A; e.pc = Issue_pc; e.rob = Issue_Reorder;
            e.qj = Issue_Qj_S ? int'(Issue_Qj) : -1;
            e.qk = Issue_Qk_S ? int'(Issue_Qk) : -1;
            if (bus_has(e.qj)) begin e.vj = bus_val(e.qj); e.qj = -1; end
            if (bus_has(e.qk)) begin e.vk = bus_val(e.qk); e.qk = -1; end
            mdl[fr] = e;
        end
    endtask

    task automatic rand_inputs();
        rdy        = ($urandom_range(0, 9) != 0);
        Clear      = rdy && ($urandom_range(0, 49) == 0);
        Issue_S    = !model_full() && ($urandom_range(0, 2) != 0);
        Issue_Op   = 6'($urandom_range(0, 63));
        Issue_Vj   = $urandom();
        Issue_Vk   = $urandom();
        Issue_A    = $urandom();
        Issue_pc   = $urandom();
        Issue_Qj_S = 1'($urandom_range(0, 1));
        Issue_Qk_S = 1'($urandom_range(0, 1));
        Issue_Qj   = 4'($urandom_range(0, 3));
        Issue_Qk   = 4'($urandom_range(0, 3));
        Issue_Reorder   = 4'($urandom_range(0, 15));
        CDB_ALU_S       = rdy && ($urandom_range(0, 1) == 1);
        CDB_ALU_Reorder = 4'($urandom_range(0, 3));
        CDB_ALU_Value   = $urandom();
        CDB_LSB_S       = rdy && ($urandom_range(0, 1) == 1);
        CDB_LSB_Reorder = 4'($urandom_range(0, 3));
        CDB_LSB_Value   = $urandom();
        if (CDB_ALU_S && CDB_LSB_S && CDB_ALU_Reorder == CDB_LSB_Reorder) CDB_LSB_S = 1'b0;
    endtask

    // ---------------- single-op vectors: issue with optional same-cycle broadcasts ----------------
    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj, vk, a, pc;
        logic        qj_s, qk_s;
        logic [3:0]  qj, qk, rob;
        logic        alu_s;
        logic [3:0]  alu_tag;
        logic [31:0] alu_val;
        logic        lsb_s;
        logic [3:0]  lsb_tag;
        logic [31:0] lsb_val;
        logic [31:0] exp_vj, exp_vk;
    } vec_t;

    vec_t tv [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv[0] = '{op: 6'h13, vj: 32'd5, vk: 32'd0, a: 32'd7, pc: 32'h1000, qj_s: 0, qk_s: 0, qj: 0, qk: 0,
                  rob: 4'd3, alu_s: 0, alu_tag: 0, alu_val: 0, lsb_s: 0, lsb_tag: 0, lsb_val: 0,
                  exp_vj: 32'd5, exp_vk: 32'd0};
        tv[1] = '{op: 6'h20, vj: 32'd9, vk: 32'h1111, a: 32'd0, pc: 32'h1004, qj_s: 0, qk_s: 1, qj: 0, qk: 4'd5,
                  rob: 4'd6, alu_s: 0, alu_tag: 0, alu_val: 0, lsb_s: 1, lsb_tag: 4'd5, lsb_val: 32'hABCD,
                  exp_vj: 32'd9, exp_vk: 32'hABCD};
        tv[2] = '{op: 6'h21, vj: 32'h2222, vk: 32'h30, a: 32'd1, pc: 32'h1008, qj_s: 1, qk_s: 0, qj: 4'd2, qk: 0,
                  rob: 4'd7, alu_s: 1, alu_tag: 4'd2, alu_val: 32'h10, lsb_s: 0, lsb_tag: 0, lsb_val: 0,
                  exp_vj: 32'h10, exp_vk: 32'h30};
        tv[3] = '{op: 6'h22, vj: 32'h0, vk: 32'h0, a: 32'd2, pc: 32'h100C, qj_s: 1, qk_s: 1, qj: 4'd8, qk: 4'd9,
                  rob: 4'd15, alu_s: 1, alu_tag: 4'd8, alu_val: 32'hAAAA_0001, lsb_s: 1, lsb_tag: 4'd9,
                  lsb_val: 32'h5555_0002, exp_vj: 32'hAAAA_0001, exp_vk: 32'h5555_0002};
        tv[4] = '{op: 6'h3F, vj: 32'h1234, vk: 32'hFFFF_FFFF, a: 32'h8000_0000, pc: 32'hFFFF_FFFC, qj_s: 0,
                  qk_s: 0, qj: 4'd4, qk: 0, rob: 4'd0, alu_s: 1, alu_tag: 4'd4, alu_val: 32'h9999, lsb_s: 0,
                  lsb_tag: 0, lsb_val: 0, exp_vj: 32'h1234, exp_vk: 32'hFFFF_FFFF};

        // Power-up reset, checked while rst_n is still low.
        #12;
        check("reset_alu_s", ALU_S, 0);
        check("reset_full", RS_Full, 0);
        check("reset_out", dut_out, 0);
        rst_n = 1'b1;
        tick();

        foreach (tv[i]) begin
            issue(tv[i].op, tv[i].vj, tv[i].vk, tv[i].qj_s, tv[i].qj, tv[i].qk_s, tv[i].qk,
                  tv[i].rob, tv[i].a, tv[i].pc);
            CDB_ALU_S = tv[i].alu_s; CDB_ALU_Reorder = tv[i].alu_tag; CDB_ALU_Value = tv[i].alu_val;
            CDB_LSB_S = tv[i].lsb_s; CDB_LSB_Reorder = tv[i].lsb_tag; CDB_LSB_Value = tv[i].lsb_val;
            tick();
            idle();
            check($sformatf("vec%0d_t+1", i), ALU_S, 0);
            tick();
            check($sformatf("vec%0d_alu_s", i), ALU_S, 1);
            check($sformatf("vec%0d_out", i), dut_out,
                  {tv[i].op, tv[i].exp_vj, tv[i].exp_vk, tv[i].a, tv[i].pc, tv[i].rob});
            tick();
            check($sformatf("vec%0d_t+3", i), ALU_S, 0);
        end

        // Pending operand woken by the ALU bus.
        issue(6'h01, 32'hFFFF, 32'h1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4, 32'h0, 32'h40);
        tick(); idle();
        tick();
        check("wake_wait", ALU_S, 0);
        CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd2; CDB_ALU_Value = 32'h10;
        tick(); idle();
        for (int c = 1; c < WAKE_LAT; c++) tick();
        check("wake_alu_s", ALU_S, 1);
        check("wake_out", dut_out, {6'h01, 32'h10, 32'h1, 32'h0, 32'h40, 4'd4});
        tick();
        check("wake_after", ALU_S, 0);

        // Fill every slot pending on tag 1, try one more, then release them all.
        for (int i = 0; i < DEPTH; i++) begin
            issue(6'h02, 32'h0, 32'(i), 1'b1, 4'd1, 1'b0, 4'd0, 4'(i), 32'h0, 32'h100 + 32'(i));
            tick();
        end
        idle();
        check("full_set", RS_Full, 1);
        issue(6'h03, 32'h0, 32'h0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd9, 32'h0, 32'hDEAD);
        tick(); idle();
        check("full_extra_ignored", RS_Full, 1);
        CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd1; CDB_ALU_Value = 32'h77;
        tick(); idle();
        for (int c = 1; c < WAKE_LAT; c++) tick();
        check("full_drop", RS_Full, 0);
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("drain%0d_alu_s", k), ALU_S, 1);
            check($sformatf("drain%0d_out", k), dut_out,
                  {6'h02, 32'h77, 32'(k), 32'h0, 32'h100 + 32'(k), 4'(k)});
            tick();
        end
        check("drain_done", ALU_S, 0);

        // Clear with four waiting entries and a same-cycle issue.
        for (int i = 0; i < 4; i++) begin
            issue(6'h05, 32'h0, 32'h0, 1'b1, 4'd7, 1'b0, 4'd0, 4'(i), 32'h0, 32'h200 + 32'(i));
            tick();
        end
        idle();
        Clear = 1'b1;
        issue(6'h06, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 32'h0, 32'h300);
        tick(); idle();
        check("clear_full", RS_Full, 0);
        check("clear_alu_s", ALU_S, 0);
        CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd7; CDB_ALU_Value = 32'h7777;
        tick(); idle();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("clear_quiet%0d", c), ALU_S, 0);
            tick();
        end

        // rdy stall with a ready entry.
        issue(6'h07, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2, 32'h3, 32'h400);
        tick(); idle();
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d", c), ALU_S, 0);
        end
        rdy = 1'b1;
        tick();
        check("stall_release", ALU_S, 1);
        check("stall_out", dut_out, {6'h07, 32'h55, 32'h66, 32'h3, 32'h400, 4'd2});
        rdy = 1'b0;
        #1;
        check("rdy_gate_comb", ALU_S, 0);
        tick();
        rdy = 1'b1;
        #1;
        check("rdy_gate_reg", ALU_S, 0);

        // Asynchronous reset in the middle of a dispatch stream.
        for (int i = 0; i < 3; i++) begin
            issue(6'h0A, 32'hA0 + 32'(i), 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'(i), 32'h0, 32'h500 + 32'(i));
            tick();
        end
        idle();
        check("mid_stream_alu_s", ALU_S, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_alu_s", ALU_S, 0);
        check("mid_rst_full", RS_Full, 0);
        check("mid_rst_out", dut_out, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("post_rst_quiet%0d", c), ALU_S, 0);
        end

        // Randomized run against the model.
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            rand_inputs();
            model_edge();
            tick();
            check("rnd_alu_s", ALU_S, exp_alu_s);
            check("rnd_out", dut_out, exp_out);
            check("rnd_full", RS_Full, model_full());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
